// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - DMOp encodings and the store-buffer entry type shared with dm
package dm_pkg;

  localparam logic [2:0] DM_W   = 3'b000;
  localparam logic [2:0] DM_H   = 3'b001;
  localparam logic [2:0] DM_B   = 3'b010;
  localparam logic [2:0] DM_UHB = 3'b100;

  // Byte address width of the dm port; entries are sized to it.
  localparam int DM_AW = 9;

  typedef struct packed {
    logic [2:0]       op;
    logic [DM_AW-1:0] addr;
    logic [31:0]      data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - word-granular compare of a load address against all live entries
module sb_match #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 9,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic [PW-1:0] head_i,
  input  logic [PW:0]   count_i,
  input  logic [AW-3:0] word_i [DEPTH],
  input  logic [AW-3:0] ld_word_i,
  output logic          conflict_o
);

  logic [PW-1:0] offset;

  // An entry is live when its distance from head, modulo DEPTH, is below count.
  always_comb begin
    conflict_o = 1'b0;
    offset     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - head_i;
      if (({1'b0, offset} < count_i) && (word_i[i] == ld_word_i)) begin
        conflict_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write FIFO in front of dm with load/store port arbitration
module store_buffer
  import dm_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int AW    = DM_AW,
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          st_valid,
  input  logic [2:0]    st_op,
  input  logic [AW-1:0] st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  input  logic          ld_req,
  input  logic [2:0]    ld_op,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_stall,
  output logic          dm_wr,
  output logic [2:0]    dm_op,
  output logic [AW-1:0] dm_addr,
  output logic [31:0]   dm_din,
  output logic          empty
);

  sb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic [AW-1:0] entry_addr [DEPTH];
  logic [AW-3:0] entry_word [DEPTH];
  logic          conflict;
  logic          enq;
  logic          drain;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_addr[i] = AW'(mem_q[i].addr);
      entry_word[i] = entry_addr[i][AW-1:2];
    end
  end

  sb_match #(.DEPTH(DEPTH), .AW(AW)) u_match (
    .head_i     (head_q),
    .count_i    (count_q),
    .word_i     (entry_word),
    .ld_word_i  (ld_addr[AW-1:2]),
    .conflict_o (conflict)
  );

  // No bypass when full: readiness looks only at the registered count.
  assign st_ready = (count_q != (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign ld_stall = ld_req & conflict;
  assign enq      = st_valid & st_ready;

  always_comb begin
    drain   = 1'b0;
    dm_wr   = 1'b0;
    dm_op   = ld_op;
    dm_addr = ld_addr;
    dm_din  = '0;
    if (!(ld_req && !conflict) && (count_q != '0)) begin
      drain   = 1'b1;
      dm_wr   = 1'b1;
      dm_op   = mem_q[head_q].op;
      dm_addr = entry_addr[head_q];
      dm_din  = mem_q[head_q].data;
    end
  end

  always_comb begin
    head_d  = drain ? head_q + 1'b1 : head_q;
    tail_d  = enq   ? tail_q + 1'b1 : tail_q;
    count_d = count_q;
    case ({enq, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset; liveness is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[tail_q] <= '{op: st_op, addr: DM_AW'(st_addr), data: st_data};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        st_valid;
  logic [2:0]  st_op;
  logic [8:0]  st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_req;
  logic [2:0]  ld_op;
  logic [8:0]  ld_addr;
  logic        ld_stall;
  logic        dm_wr;
  logic [2:0]  dm_op;
  logic [8:0]  dm_addr;
  logic [31:0] dm_din;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .AW(9)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .st_valid (st_valid),
    .st_op    (st_op),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_ready (st_ready),
    .ld_req   (ld_req),
    .ld_op    (ld_op),
    .ld_addr  (ld_addr),
    .ld_stall (ld_stall),
    .dm_wr    (dm_wr),
    .dm_op    (dm_op),
    .dm_addr  (dm_addr),
    .dm_din   (dm_din),
    .empty    (empty)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_store(input logic [2:0] op, input logic [8:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_op    = op;
    st_addr  = a;
    st_data  = d;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] exp_d;
  logic [8:0]  exp_a;

  initial begin
    rstn = 1'b0; st_valid = 1'b0; st_op = DM_W; st_addr = '0; st_data = '0;
    ld_req = 1'b0; ld_op = DM_W; ld_addr = '0;
    step(); step();
    #2;
    check_eq("rst_empty",    32'(empty),    32'd1);
    check_eq("rst_st_ready", 32'(st_ready), 32'd1);
    check_eq("rst_dm_wr",    32'(dm_wr),    32'd0);
    check_eq("rst_dm_addr",  32'(dm_addr),  32'd0);
    check_eq("rst_dm_din",   dm_din,        32'd0);
    check_eq("rst_ld_stall", 32'(ld_stall), 32'd0);
    check_eq("rst_dm_op",    32'(dm_op),    32'd0);
    step();
    rstn = 1'b1;
    step();

    // Single word store drains the next cycle.
    put_store(DM_W, 9'h010, 32'h11223344);
    #2;
    check_eq("idle_dm_wr", 32'(dm_wr), 32'd0);
    step();
    st_valid = 1'b0;
    #2;
    check_eq("st1_dm_wr",   32'(dm_wr),   32'd1);
    check_eq("st1_dm_addr", 32'(dm_addr), 32'h010);
    check_eq("st1_dm_din",  dm_din,       32'h11223344);
    check_eq("st1_dm_op",   32'(dm_op),   32'(DM_W));
    check_eq("st1_empty",   32'(empty),   32'd0);
    step();
    #2;
    check_eq("st1_empty_after", 32'(empty), 32'd1);
    check_eq("st1_wr_after",    32'(dm_wr), 32'd0);

    // Fill to full while a non-conflicting load holds the port.
    step();
    ld_req = 1'b1; ld_op = DM_W; ld_addr = 9'h100;
    for (int i = 0; i < 4; i++) begin
      put_store(DM_W, 9'h020 + 9'(4 * i), 32'hA000_0000 + 32'(i));
      #2;
      check_eq("fill_dm_wr", 32'(dm_wr), 32'd0);
      step();
    end
    st_valid = 1'b0;
    #2;
    check_eq("full_st_ready", 32'(st_ready), 32'd0);
    check_eq("full_dm_wr",    32'(dm_wr),    32'd0);
    check_eq("full_dm_addr",  32'(dm_addr),  32'h100);
    step();
    ld_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      check_eq("ret_dm_wr",   32'(dm_wr),   32'd1);
      check_eq("ret_dm_addr", 32'(dm_addr), 32'h020 + 32'(4 * i));
      check_eq("ret_dm_din",  dm_din,       32'hA000_0000 + 32'(i));
      check_eq("ret_st_ready", 32'(st_ready), (i == 0) ? 32'd0 : 32'd1);
      step();
    end
    #2;
    check_eq("ret_empty", 32'(empty), 32'd1);

    // Byte store at 0x013 conflicts with a word load at 0x010.
    step();
    put_store(DM_B, 9'h013, 32'h0000_00AB);
    step();
    st_valid = 1'b0;
    ld_req = 1'b1; ld_op = DM_W; ld_addr = 9'h010;
    #2;
    check_eq("cf_ld_stall", 32'(ld_stall), 32'd1);
    check_eq("cf_dm_wr",    32'(dm_wr),    32'd1);
    check_eq("cf_dm_addr",  32'(dm_addr),  32'h013);
    check_eq("cf_dm_op",    32'(dm_op),    32'(DM_B));
    step();
    #2;
    check_eq("cf2_ld_stall", 32'(ld_stall), 32'd0);
    check_eq("cf2_dm_addr",  32'(dm_addr),  32'h010);
    check_eq("cf2_dm_wr",    32'(dm_wr),    32'd0);
    ld_req = 1'b0;

    // Adjacent word: load H at 0x014 against a store to 0x010 is not a conflict.
    step();
    put_store(DM_W, 9'h010, 32'h5555_5555);
    step();
    st_valid = 1'b0;
    ld_req = 1'b1; ld_op = DM_H; ld_addr = 9'h014;
    #2;
    check_eq("nc_ld_stall", 32'(ld_stall), 32'd0);
    check_eq("nc_dm_wr",    32'(dm_wr),    32'd0);
    check_eq("nc_dm_addr",  32'(dm_addr),  32'h014);
    check_eq("nc_dm_op",    32'(dm_op),    32'(DM_H));
    step();
    ld_req = 1'b0;
    #2;
    check_eq("nc_drain_wr",   32'(dm_wr),   32'd1);
    check_eq("nc_drain_addr", 32'(dm_addr), 32'h010);
    step();

    // Steady state: two entries held, one in and one out every cycle across wraps.
    ld_req = 1'b1; ld_op = DM_W; ld_addr = 9'h100;
    for (int i = 0; i < 2; i++) begin
      exp_d = 32'hC000_0000 + 32'(i);
      put_store(DM_W, 9'h040 + 9'(4 * i), exp_d);
      exp_q.push_back(exp_d);
      step();
    end
    ld_req = 1'b0;
    for (int i = 2; i < 22; i++) begin
      exp_d = 32'hC000_0000 + 32'(i);
      put_store(DM_W, 9'h040 + 9'(4 * (i % 8)), exp_d);
      #2;
      check_eq("ss_dm_wr",    32'(dm_wr),    32'd1);
      check_eq("ss_dm_din",   dm_din,        exp_q.pop_front());
      check_eq("ss_st_ready", 32'(st_ready), 32'd1);
      check_eq("ss_empty",    32'(empty),    32'd0);
      exp_q.push_back(exp_d);
      step();
    end
    st_valid = 1'b0;
    while (exp_q.size() != 0) begin
      #2;
      check_eq("ss_tail_din", dm_din, exp_q.pop_front());
      step();
    end
    #2;
    check_eq("ss_final_empty", 32'(empty), 32'd1);

    // Reset with three entries pending discards them immediately.
    step();
    ld_req = 1'b1; ld_addr = 9'h100;
    for (int i = 0; i < 3; i++) begin
      put_store(DM_W, 9'h080 + 9'(4 * i), 32'hD000_0000 + 32'(i));
      step();
    end
    st_valid = 1'b0;
    ld_req = 1'b0;
    ld_addr = '0;
    #2;
    exp_a = 9'h080;
    check_eq("pre_rst_dm_wr",   32'(dm_wr),   32'd1);
    check_eq("pre_rst_dm_addr", 32'(dm_addr), 32'(exp_a));
    rstn = 1'b0;
    #1;
    check_eq("mid_rst_empty",    32'(empty),    32'd1);
    check_eq("mid_rst_dm_wr",    32'(dm_wr),    32'd0);
    check_eq("mid_rst_st_ready", 32'(st_ready), 32'd1);
    step();
    rstn = 1'b1;
    step();
    #2;
    check_eq("post_rst_empty", 32'(empty), 32'd1);
    check_eq("post_rst_dm_wr", 32'(dm_wr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
